// File: rtl/ysyx_23060201_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060201_pkg
// Description : Shared definitions for the NPC register file. Holds default
//               widths and a helper that locates one port's slice inside a
//               packed multi-port bus.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060201_pkg;

  localparam int GPR_ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF     = 32;

  // LSB position of port 'port' in a packed bus of 'width'-bit fields.
  // Use as bus[port_lsb(p, W) +: W].
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060201_gpr_wsel.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060201_gpr_wsel
// Description : Combinational priority select of write-port data for one
//               register address. When several enabled write ports target
//               addr_i, the highest-numbered port wins.
// Ports       : wen_i   - per-port write enable
//               waddr_i - packed write addresses
//               wdata_i - packed write data
//               addr_i  - address being looked up
//               hit_o   - some enabled port targets addr_i
//               data_o  - data of the winning port (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060201_gpr_wsel
  import ysyx_23060201_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = GPR_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int NUM_WR         = 2
) (
  input  logic [NUM_WR-1:0]                wen_i,
  input  logic [NUM_WR*GPR_ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]     wdata_i,
  input  logic [GPR_ADDR_WIDTH-1:0]        addr_i,
  output logic                             hit_o,
  output logic [DATA_WIDTH-1:0]            data_o
);

  // Ascending scan: a later (higher) port overwrites an earlier match,
  // which gives the highest-index-wins priority.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen_i[j] &&
          (waddr_i[port_lsb(j, GPR_ADDR_WIDTH) +: GPR_ADDR_WIDTH] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060201_gpr_mp.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060201_gpr_mp
// Description : Multi-port general-purpose register file with a pending-write
//               scoreboard. NUM_RD combinational read ports, NUM_WR write
//               ports, optional same-cycle write-to-read bypass, and one busy
//               bit per register set on issue and cleared on writeback.
// Ports       : gpr_clk/gpr_rst      - clock, synchronous active-high reset
//               gpr_ren/raddr/rdata  - read ports (packed), rdata combinational
//               gpr_rbusy            - busy bit of each read port's register
//               gpr_wen/waddr/wdata  - write ports (packed)
//               gpr_iss/gpr_iss_addr - mark destination register busy
//               gpr_busy             - full registered scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060201_gpr_mp
  import ysyx_23060201_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = GPR_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 2,
  parameter int BYPASS         = 1
) (
  input  logic                             gpr_clk,
  input  logic                             gpr_rst,
  input  logic [NUM_RD-1:0]                gpr_ren,
  input  logic [NUM_RD*GPR_ADDR_WIDTH-1:0] gpr_raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     gpr_rdata,
  output logic [NUM_RD-1:0]                gpr_rbusy,
  input  logic [NUM_WR-1:0]                gpr_wen,
  input  logic [NUM_WR*GPR_ADDR_WIDTH-1:0] gpr_waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]     gpr_wdata,
  input  logic                             gpr_iss,
  input  logic [GPR_ADDR_WIDTH-1:0]        gpr_iss_addr,
  output logic [(2**GPR_ADDR_WIDTH)-1:0]   gpr_busy
);

  localparam int DEPTH = 2 ** GPR_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  // Per-entry write resolution. Entry 0 is hardwired, so it has no selector.
  logic                  wr_hit  [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] wr_data [1:DEPTH-1];

  for (genvar k = 1; k < DEPTH; k++) begin : g_wsel_entry
    localparam logic [GPR_ADDR_WIDTH-1:0] ENTRY_ADDR = GPR_ADDR_WIDTH'(k);

    ysyx_23060201_gpr_wsel #(
      .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .NUM_WR         (NUM_WR)
    ) u_wsel (
      .wen_i   (gpr_wen),
      .waddr_i (gpr_waddr),
      .wdata_i (gpr_wdata),
      .addr_i  (ENTRY_ADDR),
      .hit_o   (wr_hit[k]),
      .data_o  (wr_data[k])
    );
  end

  // Scoreboard next state: issue sets, writeback clears, and the set wins
  // because a newly issued producer supersedes the one completing now.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (gpr_iss && (gpr_iss_addr == GPR_ADDR_WIDTH'(k))) begin
        busy_d[k] = 1'b1;
      end else if (wr_hit[k]) begin
        busy_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge gpr_clk) begin
    if (gpr_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (wr_hit[k]) begin
          regs_q[k] <= wr_data[k];
        end
      end
      busy_q <= busy_d;
    end
  end

  assign gpr_busy = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
    logic [GPR_ADDR_WIDTH-1:0] raddr;
    logic                      use_byp;
    logic [DATA_WIDTH-1:0]     byp_data;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rbusy;

    assign raddr = gpr_raddr[port_lsb(i, GPR_ADDR_WIDTH) +: GPR_ADDR_WIDTH];

    if (BYPASS != 0) begin : g_bypass
      logic byp_hit;

      ysyx_23060201_gpr_wsel #(
        .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_WR         (NUM_WR)
      ) u_wsel (
        .wen_i   (gpr_wen),
        .waddr_i (gpr_waddr),
        .wdata_i (gpr_wdata),
        .addr_i  (raddr),
        .hit_o   (byp_hit),
        .data_o  (byp_data)
      );

      assign use_byp = byp_hit;
    end else begin : g_no_bypass
      assign use_byp  = 1'b0;
      assign byp_data = '0;
    end

    // A bypassed value is resolved this cycle, so it is never reported busy.
    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (gpr_ren[i] && (raddr != '0)) begin
        if (use_byp) begin
          rdata = byp_data;
        end else begin
          rdata = regs_q[raddr];
          rbusy = busy_q[raddr];
        end
      end
    end

    assign gpr_rdata[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = rdata;
    assign gpr_rbusy[i]                                     = rbusy;
  end

endmodule
`default_nettype wire
